// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package imem_fetch_pkg;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        fault;
  } fetch_entry_t;

  localparam int unsigned INST_BYTES        = 4;
  localparam logic [19:0] IMEM_PAGE_DEFAULT = 20'd1;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_1000;

  // A PC may be fetched only if it lies in the instruction page and is word aligned
  function automatic logic pc_is_legal(input logic [31:0] pc, input logic [19:0] page);
    return (pc[31:12] == page) && (pc[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO that absorbs the memory read latency; flush beats push and pop.
module fetch_skid_buffer
  import imem_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entries [2];
  logic         wr_ptr;
  logic         rd_ptr;

  assign head = entries[rd_ptr];

  // Storage, pointers and occupancy; a flush empties the queue without touching stored words
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // The fetch credit scheme must never let a push land on a full buffer
  push_into_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == 2'd2)));

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues one read per cycle under a
// two-credit budget, tracks the in-flight read and delivers words to decode.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [19:0] IMEM_PAGE = IMEM_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data_in,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_fault
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic [31:0]  fetch_pc;
  logic         inflight;
  logic [31:0]  inflight_pc;
  logic [1:0]   count;
  fetch_entry_t head;
  fetch_entry_t push_entry;
  logic         push;
  logic         pop;
  logic         issue;
  logic         fault_push;
  logic [2:0]   credit_used;
  logic         issue_ok;

  assign imem_address = fetch_pc;
  assign inst_valid   = (count != 2'd0);
  assign inst_pc      = inst_valid ? head.pc : 32'h0;
  assign inst_data    = inst_valid ? head.data : 32'h0;
  assign inst_fault   = inst_valid & head.fault;

  // A head presented during a redirect is squashed, never consumed
  assign pop = inst_valid & inst_ready & ~redirect_valid;

  // Buffer slots promised to queued words and the outstanding read, after this cycle's pop
  assign credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue_ok    = (credit_used < 3'd2);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, read issue, fault generation and the buffer push mux
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    fault_push = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (redirect_valid) begin
      state_d = FETCH;
    end else begin
      if ((state_q == FETCH) && issue_ok) begin
        if (pc_is_legal(fetch_pc, IMEM_PAGE)) begin
          issue = 1'b1;
        end else if (!inflight) begin
          fault_push = 1'b1;
          state_d    = HALTED;
        end
      end
      if (inflight) begin
        push       = 1'b1;
        push_entry = '{pc: inflight_pc, data: imem_data_in, fault: 1'b0};
      end else if (fault_push) begin
        push       = 1'b1;
        push_entry = '{pc: fetch_pc, data: 32'h0, fault: 1'b1};
      end
    end
  end

  // Fetch PC and in-flight read tracking; a redirect discards the outstanding read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'(INST_BYTES);
      end
    end
  end

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_entry (push_entry),
    .count      (count),
    .head       (head)
  );

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed self-checking bench for imem_fetch_ctrl with a synchronous-read memory model.
module tb_imem_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_address;
  logic [31:0] imem_data_in;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_fault;

  int checks   = 0;
  int failures = 0;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_address   (imem_address),
    .imem_data_in   (imem_data_in),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory image: each word is derived from its own address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // Synchronous-read instruction memory: data appears the cycle after the address is sampled
  always @(posedge clk) begin
    imem_data_in <= memWord(imem_address);
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", tag, actual, expected);
    end
  endtask

  // Drive this cycle's inputs, then move to just after the next rising edge
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    checkOutput({tag, "_pc"}, inst_pc, pc);
    checkOutput({tag, "_data"}, inst_data, memWord(pc));
    checkOutput({tag, "_fault"}, {31'b0, inst_fault}, 32'd0);
  endtask

  task automatic checkFault(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
    checkOutput({tag, "_pc"}, inst_pc, pc);
    checkOutput({tag, "_data"}, inst_data, 32'h0);
    checkOutput({tag, "_fault"}, {31'b0, inst_fault}, 32'd1);
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_addr"}, imem_address, 32'h0000_1000);
    checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'd0);
    checkOutput({tag, "_data"}, inst_data, 32'h0);
    checkOutput({tag, "_pc"}, inst_pc, 32'h0);
    checkOutput({tag, "_fault"}, {31'b0, inst_fault}, 32'd0);
  endtask

  // Hold reset over two edges, check reset values, release; returns at the start of cycle 0
  task automatic startFromReset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;
  endtask

  // Starting in cycle 0 with decode always ready; ends in cycle 4
  task automatic runFreeRun(input string tag);
    checkEmpty({tag, "_c0"});
    checkOutput({tag, "_c0_addr"}, imem_address, 32'h0000_1000);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkEmpty({tag, "_c1"});
    checkOutput({tag, "_c1_addr"}, imem_address, 32'h0000_1004);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead({tag, "_c2"}, 32'h0000_1000);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead({tag, "_c3"}, 32'h0000_1004);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead({tag, "_c4"}, 32'h0000_1008);
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;

    // Free-run from reset
    startFromReset();
    runFreeRun("free");

    // Backpressure: decode stalls in cycles 2..7, released in cycle 8
    startFromReset();
    applyStimulus(1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int c = 2; c <= 7; c++) begin
      checkHead("bp_hold", 32'h0000_1000);
      checkOutput("bp_addr_frozen", imem_address, 32'h0000_1008);
      applyStimulus(1'b0, 32'h0, 1'b0);
    end
    checkHead("bp_rel0", 32'h0000_1000);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("bp_rel1", 32'h0000_1004);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("bp_rel2", 32'h0000_1008);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("bp_rel3", 32'h0000_100C);

    // Redirect while a read is in flight and the buffer is occupied
    applyStimulus(1'b1, 32'h0000_1800, 1'b1);
    checkEmpty("redir_r1");
    checkOutput("redir_r1_addr", imem_address, 32'h0000_1800);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkEmpty("redir_r2");
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("redir_r3", 32'h0000_1800);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("redir_r4", 32'h0000_1804);

    // Page end: two good words, then a fault at 0x2000, then silence
    applyStimulus(1'b1, 32'h0000_1FF8, 1'b1);
    checkEmpty("page_p1");
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkEmpty("page_p2");
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("page_1ff8", 32'h0000_1FF8);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("page_1ffc", 32'h0000_1FFC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkFault("page_fault", 32'h0000_2000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkEmpty("page_halted");
      checkOutput("page_halted_addr", imem_address, 32'h0000_2000);
    end
    applyStimulus(1'b1, 32'h0000_1000, 1'b1);
    checkOutput("resume_addr", imem_address, 32'h0000_1000);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("resume_1000", 32'h0000_1000);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("resume_1004", 32'h0000_1004);

    // Misaligned target: one fault entry, then halted
    applyStimulus(1'b1, 32'h0000_1002, 1'b1);
    checkEmpty("mis_m1");
    checkOutput("mis_m1_addr", imem_address, 32'h0000_1002);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkFault("mis_fault", 32'h0000_1002);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkEmpty("mis_halted");
      checkOutput("mis_halted_addr", imem_address, 32'h0000_1002);
    end

    // Fill the buffer under backpressure, then assert reset mid-cycle
    applyStimulus(1'b1, 32'h0000_1000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0);
    end
    checkHead("full_head", 32'h0000_1000);
    checkOutput("full_addr", imem_address, 32'h0000_1008);
    #3;
    rst = 1'b1;
    #1;
    checkResetValues("async_reset");
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    rst        = 1'b0;
    runFreeRun("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer that sits between the core's decode stage and `instruction_mem`. It owns the fetch PC, issues one word read per cycle into the synchronous-read instruction memory, and absorbs the one-cycle read latency with a 2-entry skid buffer. It presents instructions to decode over a valid/ready handshake and handles control-flow redirects and fetch faults (out-of-page or misaligned PC).

## Interface
- `RESET_PC`, 32'h0000_1000, fetch PC loaded on reset.
- `IMEM_PAGE`, 20'd1, value of address[31:12] that selects instruction memory.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_valid`  in  1  load `redirect_pc` as the new fetch PC this cycle.
- `redirect_pc`  in  32  redirect target.
- `imem_address`  out  32  address to `instruction_mem`; equals internal fetch PC register.
- `imem_data_in`  in  32  read data from `instruction_mem`, valid the cycle after the address was sampled.
- `inst_valid`  out  1  buffer head holds an instruction.
- `inst_ready`  in  1  decode accepts head this cycle.
- `inst_data`  out  32  instruction word (0 when `inst_fault`).
- `inst_pc`  out  32  PC of `inst_data`.
- `inst_fault`  out  1  head entry is a fetch fault.

## Operation
- States: FETCH, HALTED. Reset → FETCH.
- Credit rule: `issue_ok = (count + inflight - pop) < 2`, where `count` is buffer occupancy (0..2), `inflight` means a read was issued last edge, and `pop = inst_valid & inst_ready`.
- FETCH, `issue_ok`, no redirect, PC legal: at the edge, memory samples `fetch_pc`; set `inflight`, `inflight_pc <= fetch_pc`, `fetch_pc <= fetch_pc + 4`.
- PC legal means `fetch_pc[31:12] == IMEM_PAGE` and `fetch_pc[1:0] == 0`.
- FETCH, `issue_ok`, PC illegal: issue no read. Push a fault entry {pc=`fetch_pc`, data=0, fault=1}, hold `fetch_pc`, and go to HALTED. The fault entry is pushed after any in-flight response, so order is preserved.
- Response: when `inflight` is set, push {`inflight_pc`, `imem_data_in`, 0} into the buffer at the next edge.
- HALTED: no issues, and the buffer drains normally. Only a redirect leaves HALTED (→ FETCH).
- Redirect (either state) has top priority:
  - flush the buffer (count ← 0);
  - clear `inflight` and discard its response;
  - `fetch_pc <= redirect_pc`;
  - go to FETCH.
  - Any head presented in the redirect cycle is discarded even if `inst_ready` is high; decode must treat it as squashed.
- Push and pop in the same cycle are allowed; count is unchanged.
- The credit rule guarantees a push never finds the buffer full. A push into a full buffer is an assertion failure.
- PC arithmetic is modulo 2^32. Stepping from 0x0000_1FFC gives 0x0000_2000, which is out-of-page and therefore faults.

## Timing
- Reset values:
  - `imem_address` = `RESET_PC`;
  - `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0, `inst_fault` = 0;
  - `count` = 0, `inflight` = 0, state FETCH.
- Cycle 0 is the first cycle with `rst` low.
  - First edge: issues `RESET_PC`.
  - Cycle 1: data is on `imem_data_in`.
  - Cycle 2: `inst_valid` = 1 with pc 0x1000.
- Fetch-to-delivery latency is 2 cycles. Throughput is 1 instruction/cycle with `inst_ready` held high.
- Redirect asserted in cycle R: `imem_address` = `redirect_pc` in R+1, and the target is delivered in R+3.
- Backpressure: at most 2 entries are buffered, and `imem_address` stops advancing once credits are exhausted. Head outputs remain stable while `inst_valid & !inst_ready`.
- Reset asserted mid-operation immediately (asynchronously) forces all outputs to their reset values and drops buffered and in-flight data.

## Structure
- Package `imem_fetch_pkg` holds:
  - `fetch_state_t` enum {FETCH, HALTED};
  - `fetch_entry_t` struct {pc[31:0], data[31:0], fault};
  - constants `INST_BYTES` = 4, `IMEM_PAGE_DEFAULT` = 20'd1, `RESET_PC_DEFAULT` = 32'h0000_1000.
- Sub-module `fetch_skid_buffer`: 2-entry FIFO of `fetch_entry_t` with push, pop, flush, count and head. Flush has priority over push and pop.
- `imem_fetch_ctrl` contains the FSM, credit logic, PC register and in-flight tracking, and instantiates `fetch_skid_buffer`.

## Test plan
- Free-run: reset, then `inst_ready`=1 → `inst_valid` first high in cycle 2 with pc 0x1000, then 0x1004, 0x1008 on consecutive cycles, with `inst_data` matching memory image words 0, 1, 2.
- Backpressure: `inst_ready`=0 for cycles 2–7 → head stays at pc 0x1000, `imem_address` freezes at 0x1008, and count = 2. Release → 0x1000, 0x1004, 0x1008 are delivered back-to-back with no gap and no duplicate.
- Redirect in flight: in steady state, redirect to 0x1800 in cycle R → no pc in the range 0x100x appears after R, and pc 0x1800 is delivered in R+3, followed by 0x1804.
- Page end: redirect to 0x1FF8 → 0x1FF8 and 0x1FFC are delivered, then a fault entry with pc 0x2000, data 0, fault 1. After that, `inst_valid` stays 0 for 10 cycles. Redirect to 0x1000 → normal fetch resumes.
- Misaligned: redirect to 0x1002 → a single fault entry with pc 0x1002 and no memory read. State is HALTED until the next redirect.
- Async reset: assert `rst` mid-cycle with the buffer full and `inst_ready`=0 → `inst_valid` drops immediately and `imem_address` = 0x1000. After release, the sequence restarts exactly as in free-run.
